// File: rtl/mailbox_pkg.sv
// Shared defaults and helpers for the mailbox register file.
package mailbox_pkg;

   localparam int unsigned DefDataW = 32;
   localparam int unsigned DefAddrW = 4;
   localparam int unsigned NBYTES   = DefDataW / 8;

   // Expands one byte strobe into the bit mask applied to that byte lane.
   function automatic logic [7:0] byte_mask(input logic strb);
      return {8{strb}};
   endfunction

endpackage

// File: rtl/mailbox_regfile_if.sv
// Request/response bundle between the AHB slave datapath and the mailbox register file.
interface mailbox_regfile_if
   import mailbox_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned ADDR_W = DefAddrW
);
   localparam int unsigned NEnt = 2**ADDR_W;

   logic                  Clear;
   logic                  Wr_En;
   logic [ADDR_W-1:0]     Wr_Addr;
   logic [DATA_W-1:0]     Wr_Data;
   logic [DATA_W/8-1:0]   Wr_Strb;
   logic                  Rd_En;
   logic [ADDR_W-1:0]     Rd_Addr;
   logic                  Wr_Ack;
   logic                  Wr_Err;
   logic                  Rd_Valid;
   logic [DATA_W-1:0]     Rd_Data;
   logic                  Rd_Err;
   logic [NEnt-1:0]       Full_Map;
   logic [ADDR_W:0]       Occupancy;
   logic                  All_Full;
   logic                  All_Empty;
   logic                  Par_Err;

   modport master (
      output Clear, Wr_En, Wr_Addr, Wr_Data, Wr_Strb, Rd_En, Rd_Addr,
      input  Wr_Ack, Wr_Err, Rd_Valid, Rd_Data, Rd_Err, Full_Map, Occupancy,
             All_Full, All_Empty, Par_Err
   );

   modport slave (
      input  Clear, Wr_En, Wr_Addr, Wr_Data, Wr_Strb, Rd_En, Rd_Addr,
      output Wr_Ack, Wr_Err, Rd_Valid, Rd_Data, Rd_Err, Full_Map, Occupancy,
             All_Full, All_Empty, Par_Err
   );

endinterface

// File: rtl/mailbox_parity.sv
// Combinational per-byte even-parity generator; only built when MAILBOX_PARITY_EN is defined.
`ifdef MAILBOX_PARITY_EN
module mailbox_parity
   import mailbox_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW
) (
   input  logic [DATA_W-1:0]   data_i,
   output logic [DATA_W/8-1:0] par_o
);

   always_comb begin
      par_o = '0;
      for (int unsigned b = 0; b < DATA_W / 8; b++) begin
         par_o[b] = ^data_i[8*b +: 8];
      end
   end

endmodule
`endif

// File: rtl/mailbox_regfile.sv
// Mailbox register file: per-entry full flags, registered ack/error responses, occupancy status.
// MAILBOX_PARITY_EN adds per-byte parity storage and read-side checking with a sticky Par_Err.
module mailbox_regfile
   import mailbox_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned ADDR_W = DefAddrW
) (
   input  logic               CLK,
   input  logic               RST,
   mailbox_regfile_if.slave   bus
);

   localparam int unsigned   NEnt   = 2**ADDR_W;
   localparam int unsigned   NBytes = DATA_W / 8;
   localparam logic [ADDR_W:0] OccMax = (ADDR_W+1)'(NEnt);

   logic [DATA_W-1:0] mem_q [NEnt];
   logic [DATA_W-1:0] mem_d [NEnt];
   logic [NEnt-1:0]   full_q, full_d;
   logic [ADDR_W:0]   occ_q, occ_d;
   logic              wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
   logic              rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              all_full_q, all_full_d, all_empty_q, all_empty_d;

   logic [DATA_W-1:0] wr_mask, wr_word;
   logic              rd_hit, rd_ok, wr_ok, par_bad;

   always_comb begin
      wr_mask = '0;
      for (int unsigned b = 0; b < NBytes; b++) begin
         wr_mask[8*b +: 8] = byte_mask(bus.Wr_Strb[b]);
      end
   end
   assign wr_word = bus.Wr_Data & wr_mask;

`ifdef MAILBOX_PARITY_EN
   logic [NBytes-1:0] par_q [NEnt];
   logic [NBytes-1:0] par_d [NEnt];
   logic [NBytes-1:0] wr_par, rd_par;
   logic              par_err_q, par_err_d;

   mailbox_parity #(.DATA_W(DATA_W)) u_wr_par (.data_i(wr_word), .par_o(wr_par));
   mailbox_parity #(.DATA_W(DATA_W)) u_rd_par (.data_i(mem_q[bus.Rd_Addr]), .par_o(rd_par));

   assign par_bad = rd_hit && (rd_par != par_q[bus.Rd_Addr]);

   always_comb begin
      par_d = par_q;
      if (wr_ok) par_d[bus.Wr_Addr] = wr_par;
      par_err_d = bus.Clear ? 1'b0 : (par_err_q | par_bad);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < int'(NEnt); i++) par_q[i] <= '0;
         par_err_q <= 1'b0;
      end else begin
         par_q     <= par_d;
         par_err_q <= par_err_d;
      end
   end

   assign bus.Par_Err = par_err_q;
`else
   assign par_bad     = 1'b0;
   assign bus.Par_Err = 1'b0;
`endif

   always_comb begin
      // A read of a full entry frees it this cycle, so a same-address write may refill it.
      rd_hit = bus.Rd_En && !bus.Clear && full_q[bus.Rd_Addr];
      rd_ok  = rd_hit && !par_bad;
      wr_ok  = bus.Wr_En && !bus.Clear &&
               (!full_q[bus.Wr_Addr] || (rd_hit && (bus.Rd_Addr == bus.Wr_Addr)));

      mem_d  = mem_q;
      full_d = full_q;
      if (bus.Clear) begin
         full_d = '0;
         occ_d  = '0;
      end else begin
         if (rd_hit) full_d[bus.Rd_Addr] = 1'b0;
         if (wr_ok) begin
            full_d[bus.Wr_Addr] = 1'b1;
            mem_d[bus.Wr_Addr]  = wr_word;
         end
         occ_d = occ_q + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, rd_hit};
      end

      wr_ack_d    = wr_ok;
      wr_err_d    = bus.Wr_En && !wr_ok;
      rd_valid_d  = rd_ok;
      rd_err_d    = bus.Rd_En && !rd_ok;
      rd_data_d   = rd_ok ? mem_q[bus.Rd_Addr] : '0;
      all_full_d  = (occ_d == OccMax);
      all_empty_d = (occ_d == '0);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < int'(NEnt); i++) mem_q[i] <= '0;
         full_q      <= '0;
         occ_q       <= '0;
         wr_ack_q    <= 1'b0;
         wr_err_q    <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_err_q    <= 1'b0;
         rd_data_q   <= '0;
         all_full_q  <= 1'b0;
         all_empty_q <= 1'b1;
      end else begin
         mem_q       <= mem_d;
         full_q      <= full_d;
         occ_q       <= occ_d;
         wr_ack_q    <= wr_ack_d;
         wr_err_q    <= wr_err_d;
         rd_valid_q  <= rd_valid_d;
         rd_err_q    <= rd_err_d;
         rd_data_q   <= rd_data_d;
         all_full_q  <= all_full_d;
         all_empty_q <= all_empty_d;
      end
   end

   assign bus.Wr_Ack    = wr_ack_q;
   assign bus.Wr_Err    = wr_err_q;
   assign bus.Rd_Valid  = rd_valid_q;
   assign bus.Rd_Data   = rd_data_q;
   assign bus.Rd_Err    = rd_err_q;
   assign bus.Full_Map  = full_q;
   assign bus.Occupancy = occ_q;
   assign bus.All_Full  = all_full_q;
   assign bus.All_Empty = all_empty_q;

endmodule

// File: tb/tb_mailbox_regfile.sv
// Self-checking bench for mailbox_regfile: directed scenarios plus randomized traffic
// compared every cycle against a behavioural mailbox model.
module tb_mailbox_regfile;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   mailbox_regfile_if #(.DATA_W(32), .ADDR_W(4)) bus ();

   mailbox_regfile #(.DATA_W(32), .ADDR_W(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model state and expected registered responses.
   logic [31:0] m_mem [16];
   bit          m_full [16];
   bit          m_par;
   bit          e_wack, e_werr, e_rv, e_rerr;
   logic [31:0] e_rdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int m_occ();
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(m_full[i]);
      return n;
   endfunction

   function automatic logic [15:0] m_map();
      logic [15:0] v = '0;
      for (int i = 0; i < 16; i++) v[i] = m_full[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_mem[i]  = '0;
         m_full[i] = 1'b0;
      end
      m_par = 1'b0;
      {e_wack, e_werr, e_rv, e_rerr} = '0;
      e_rdata = '0;
   endtask

   // Applies the request on the bus at this clock edge to the model, in mailbox order:
   // Clear wins; otherwise a read drains first and a write may then refill the entry.
   task automatic model_update();
      logic [31:0] mask;
      {e_wack, e_werr, e_rv, e_rerr} = '0;
      e_rdata = '0;
      if (bus.Clear) begin
         e_werr = bus.Wr_En;
         e_rerr = bus.Rd_En;
         for (int i = 0; i < 16; i++) m_full[i] = 1'b0;
         m_par = 1'b0;
      end else begin
         if (bus.Rd_En) begin
            if (m_full[bus.Rd_Addr]) begin
               e_rv    = 1'b1;
               e_rdata = m_mem[bus.Rd_Addr];
               m_full[bus.Rd_Addr] = 1'b0;
            end else begin
               e_rerr = 1'b1;
            end
         end
         if (bus.Wr_En) begin
            if (!m_full[bus.Wr_Addr]) begin
               mask = '0;
               for (int b = 0; b < 4; b++) if (bus.Wr_Strb[b]) mask[8*b +: 8] = 8'hFF;
               m_mem[bus.Wr_Addr]  = bus.Wr_Data & mask;
               m_full[bus.Wr_Addr] = 1'b1;
               e_wack = 1'b1;
            end else begin
               e_werr = 1'b1;
            end
         end
      end
   endtask

   task automatic compare();
      chk("Wr_Ack",    bus.Wr_Ack,    e_wack);
      chk("Wr_Err",    bus.Wr_Err,    e_werr);
      chk("Rd_Valid",  bus.Rd_Valid,  e_rv);
      chk("Rd_Err",    bus.Rd_Err,    e_rerr);
      chk("Rd_Data",   bus.Rd_Data,   e_rdata);
      chk("Full_Map",  bus.Full_Map,  m_map());
      chk("Occupancy", bus.Occupancy, m_occ());
      chk("All_Full",  bus.All_Full,  m_occ() == 16);
      chk("All_Empty", bus.All_Empty, m_occ() == 0);
      chk("Par_Err",   bus.Par_Err,   m_par);
   endtask

   task automatic idle();
      bus.Clear = 1'b0;
      bus.Wr_En = 1'b0;
      bus.Rd_En = 1'b0;
   endtask

   // One clock: model follows the request, outputs checked 1 time unit after the edge.
   task automatic step();
      @(posedge CLK);
      model_update();
      #1;
      compare();
      idle();
   endtask

   task automatic set_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.Wr_En = 1'b1; bus.Wr_Addr = a; bus.Wr_Data = d; bus.Wr_Strb = s;
   endtask

   task automatic set_rd(input logic [3:0] a);
      bus.Rd_En = 1'b1; bus.Rd_Addr = a;
   endtask

   initial begin
      idle();
      bus.Wr_Addr = '0; bus.Wr_Data = '0; bus.Wr_Strb = '0; bus.Rd_Addr = '0;
      model_reset();

      // Reset state
      #12;
      compare();
      chk("rst_all_empty", bus.All_Empty, 1'b1);
      @(negedge CLK);
      RST = 1'b1;

      // 1: read of an empty entry
      set_rd(4'd3); step();
      chk("t1_rd_err", bus.Rd_Err, 1'b1);
      chk("t1_rd_data", bus.Rd_Data, 32'h0);
      chk("t1_all_empty", bus.All_Empty, 1'b1);

      // 2: write then read back
      set_wr(4'd5, 32'hDEADBEEF, 4'hF); step();
      chk("t2_wr_ack", bus.Wr_Ack, 1'b1);
      chk("t2_full5", bus.Full_Map[5], 1'b1);
      chk("t2_occ1", bus.Occupancy, 5'd1);
      set_rd(4'd5); step();
      chk("t2_rd_valid", bus.Rd_Valid, 1'b1);
      chk("t2_rd_data", bus.Rd_Data, 32'hDEADBEEF);
      chk("t2_occ0", bus.Occupancy, 5'd0);

      // 3: second write to a full entry is rejected
      set_wr(4'd2, 32'hA5A50001, 4'hF); step();
      chk("t3_ack", bus.Wr_Ack, 1'b1);
      set_wr(4'd2, 32'h00000BAD, 4'hF); step();
      chk("t3_err", bus.Wr_Err, 1'b1);
      set_rd(4'd2); step();
      chk("t3_rd_data", bus.Rd_Data, 32'hA5A50001);

      // 4: fill everything, then same-address read+write on a full entry
      for (int i = 0; i < 16; i++) begin
         set_wr(4'(i), 32'h1000 + 32'(i), 4'hF); step();
      end
      chk("t4_all_full", bus.All_Full, 1'b1);
      set_wr(4'd7, 32'hCAFE0007, 4'hF); set_rd(4'd7); step();
      chk("t4_rd_old", bus.Rd_Data, 32'h00001007);
      chk("t4_wr_ack", bus.Wr_Ack, 1'b1);
      chk("t4_occ16", bus.Occupancy, 5'd16);
      set_rd(4'd7); step();
      chk("t4_rd_new", bus.Rd_Data, 32'hCAFE0007);

      // 5: strobe masking, then Clear beats a same-cycle write
      bus.Clear = 1'b1; step();
      set_wr(4'd1, 32'h11223344, 4'b0101); step();
      set_rd(4'd1); step();
      chk("t5_strb", bus.Rd_Data, 32'h00220044);
      set_wr(4'd3, 32'h3, 4'hF); step();
      bus.Clear = 1'b1; set_wr(4'd0, 32'h55, 4'hF); step();
      chk("t5_clr_werr", bus.Wr_Err, 1'b1);
      chk("t5_clr_occ", bus.Occupancy, 5'd0);

      // Asynchronous reset mid-operation drops the pending response
      set_wr(4'd9, 32'h99, 4'hF); step();
      set_rd(4'd9); set_wr(4'd10, 32'hAA, 4'hF);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      #1;
      model_reset();
      compare();
      idle();
      @(negedge CLK);
      RST = 1'b1;

      // Randomized traffic; addresses sometimes collide on purpose
      for (int c = 0; c < 1500; c++) begin
         bus.Clear = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 1) == 1) set_wr(4'($urandom_range(0, 15)), $urandom, 4'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 3) == 0) set_rd(bus.Wr_Addr);
            else set_rd(4'($urandom_range(0, 15)));
         end
         step();
      end

`ifdef MAILBOX_PARITY_EN
      // 6: corrupt a stored bit, read reports parity error and Par_Err sticks until Clear
      bus.Clear = 1'b1; step();
      set_wr(4'd4, 32'h0F0F0F0F, 4'hF); step();
      force dut.mem_q[4] = 32'h0F0F0F0E;
      set_rd(4'd4);
      @(posedge CLK);
      #1;
      release dut.mem_q[4];
      idle();
      m_full[4] = 1'b0;
      m_par     = 1'b1;
      chk("t6_rd_err", bus.Rd_Err, 1'b1);
      chk("t6_rd_valid", bus.Rd_Valid, 1'b0);
      chk("t6_rd_data", bus.Rd_Data, 32'h0);
      chk("t6_par_err", bus.Par_Err, 1'b1);
      {e_wack, e_werr, e_rv, e_rerr} = '0;
      e_rdata = '0;
      step();
      chk("t6_sticky", bus.Par_Err, 1'b1);
      bus.Clear = 1'b1; step();
      chk("t6_cleared", bus.Par_Err, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
